inst_fetch_ctrl: RTL
====================

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter InstWidth, default 32, instruction word width (matches decoder).
REQ-002 SHALL have parameter NumInst, default 32, instruction memory depth; InstAddrWidth = $clog2(NumInst), derived.
REQ-003 SHALL have parameter LoopCntWidth, default 16, iteration counter width.
REQ-004 SHALL have: clk_i  in  1  single clock, rising edge.
REQ-005 SHALL have: rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have: cfg_wr_en_i  in  1  instruction memory write strobe.
REQ-007 SHALL have: cfg_wr_addr_i  in  InstAddrWidth  write address.
REQ-008 SHALL have: cfg_wr_data_i  in  InstWidth  write data.
REQ-009 SHALL have: start_i  in  1  begin program execution (level sampled per cycle).
REQ-010 SHALL have: stop_i  in  1  abort execution.
REQ-011 SHALL have: loop_end_addr_i  in  InstAddrWidth  last instruction address of program body.
REQ-012 SHALL have: loop_count_i  in  LoopCntWidth  number of body iterations.
REQ-013 SHALL have: stall_i  in  1  downstream not ready (IM empty, AM busy).
REQ-014 SHALL have: inst_code_o  out  InstWidth  current instruction to decoder.
REQ-015 SHALL have: inst_valid_o  out  1  instruction issued this cycle; drives decoder enable.
REQ-016 SHALL have: pc_o  out  InstAddrWidth  current program counter.
REQ-017 SHALL have: busy_o  out  1  high while in RUN.
REQ-018 SHALL have: done_o  out  1  one-cycle pulse on normal completion.

Function
REQ-019 SHALL implement FSM states IDLE and RUN; busy_o = (state == RUN).
REQ-020 IDLE->RUN on start_i=1 and stop_i=0; loop_end_addr_i and loop_count_i captured into internal registers on that edge; pc and iteration counter cleared.
REQ-021 start_i while RUN SHALL be ignored; captured loop registers unchanged.
REQ-022 inst_code_o SHALL equal mem[pc] combinationally in RUN; all-zero in IDLE.
REQ-023 inst_valid_o = busy_o & ~stall_i; an instruction is issued only when inst_valid_o=1.
REQ-024 On issue with pc != loop_end, pc SHALL increment by 1 next cycle; stalled cycles hold pc and counter.
REQ-025 On issue with pc == loop_end: if iter == eff_count-1, SHALL pulse done_o next cycle, return to IDLE, pc=0; else pc=0 and iter+1.
REQ-026 eff_count = captured count, except captured count 0 SHALL be treated as 1.
REQ-027 pc SHALL wrap modulo NumInst if loop_end >= NumInst is not reachable (no out-of-range read).
REQ-028 stop_i=1 SHALL force IDLE, pc=0, iter=0 next cycle, no done_o; stop_i dominates start_i and completion in the same cycle.
REQ-029 cfg writes SHALL take effect next cycle in IDLE; ignored (memory unchanged) while RUN.
REQ-030 Zero issue latency: instruction at pc appears in the same cycle RUN is entered+1 (first RUN cycle).

Reset
REQ-031 rst_i=1 at a rising edge SHALL force IDLE, pc=0, iter=0, loop regs=0, done_o=0; inst_valid_o=0, busy_o=0 following.
REQ-032 Reset mid-RUN SHALL abort without done_o; instruction memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 FSM state enum and InstWidth default SHALL live in hypercorex_inst_pkg; memory is a flat register array in this module.
REQ-034 No sub-module; optional loop counter inline.

Verification
REQ-035 Load mem[0..3]=A,B,C,D, loop_end=3, count=2, start -> inst_code_o A,B,C,D,A,B,C,D on 8 consecutive valid cycles, done_o once in cycle 9, busy_o low after.
REQ-036 Same program, stall_i high on cycles 2-4 -> inst_valid_o low those cycles, pc held at 1, sequence unchanged, done_o delayed by 3 cycles.
REQ-037 count=0, loop_end=0 -> exactly one issue of mem[0], then done_o.
REQ-038 stop_i asserted at pc=2 iteration 0 -> IDLE next cycle, pc_o=0, no done_o; cfg write during RUN leaves mem unchanged on readback run.
REQ-039 rst_i at pc=3 iteration 1 -> busy_o=0, pc_o=0, done_o never asserted; restart reproduces full sequence from mem[0].

Source files
------------

// File: rtl/hypercorex_inst_pkg.sv
// rtl/hypercorex_inst_pkg.sv - shared types and defaults for the instruction fetch path
package hypercorex_inst_pkg;

  // Instruction word width shared with the decoder
  localparam int unsigned InstWidthDefault = 32;

  // Fetch sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction memory and looping program sequencer
module inst_fetch_ctrl
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned InstWidth     = InstWidthDefault,
  parameter int unsigned NumInst       = 32,
  parameter int unsigned LoopCntWidth  = 16,
  parameter int unsigned InstAddrWidth = (NumInst > 1) ? $clog2(NumInst) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_wr_en_i,
  input  logic [InstAddrWidth-1:0] cfg_wr_addr_i,
  input  logic [InstWidth-1:0]     cfg_wr_data_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [InstAddrWidth-1:0] loop_end_addr_i,
  input  logic [LoopCntWidth-1:0]  loop_count_i,
  input  logic                     stall_i,
  output logic [InstWidth-1:0]     inst_code_o,
  output logic                     inst_valid_o,
  output logic [InstAddrWidth-1:0] pc_o,
  output logic                     busy_o,
  output logic                     done_o
);

  // Program storage; deliberately not reset so a program survives aborts
  logic [InstWidth-1:0] mem [NumInst];

  fetch_state_e              state;
  logic [InstAddrWidth-1:0]  pc;
  logic [LoopCntWidth-1:0]   iter;
  logic [InstAddrWidth-1:0]  loop_end_q;
  logic [LoopCntWidth-1:0]   loop_cnt_q;
  logic                      done_q;

  logic                      busy;
  logic                      issue;
  logic                      at_loop_end;
  logic                      last_iter;
  logic                      wr_ok;
  logic [LoopCntWidth-1:0]   last_iter_idx;
  logic [InstAddrWidth-1:0]  pc_next_seq;

  // Issue qualification, loop bookkeeping and wrap-safe pc increment
  always_comb begin
    busy          = (state == RUN);
    issue         = busy & ~stall_i;
    at_loop_end   = (pc == loop_end_q);
    // A captured count of zero still runs the body once
    last_iter_idx = (loop_cnt_q == '0) ? '0 : (loop_cnt_q - LoopCntWidth'(1));
    last_iter     = (iter == last_iter_idx);
    // Wrap at the memory depth so an unreachable loop_end never reads past the array
    if (pc == InstAddrWidth'(NumInst - 1)) begin
      pc_next_seq = '0;
    end else begin
      pc_next_seq = pc + InstAddrWidth'(1);
    end
    // Guard writes for depths that are not a power of two
    wr_ok         = (32'(cfg_wr_addr_i) < NumInst);
  end

  // Configuration writes only land while the sequencer is idle
  always_ff @(posedge clk_i) begin
    if (cfg_wr_en_i && (state == IDLE) && wr_ok) begin
      mem[cfg_wr_addr_i] <= cfg_wr_data_i;
    end
  end

  // Sequencer: stop dominates start and completion; done is a registered one-cycle pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pc         <= '0;
      iter       <= '0;
      loop_end_q <= '0;
      loop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop_i) begin
        state <= IDLE;
        pc    <= '0;
        iter  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              state      <= RUN;
              pc         <= '0;
              iter       <= '0;
              loop_end_q <= loop_end_addr_i;
              loop_cnt_q <= loop_count_i;
            end
          end
          RUN: begin
            if (issue) begin
              if (at_loop_end) begin
                pc <= '0;
                if (last_iter) begin
                  state  <= IDLE;
                  iter   <= '0;
                  done_q <= 1'b1;
                end else begin
                  iter <= iter + LoopCntWidth'(1);
                end
              end else begin
                pc <= pc_next_seq;
              end
            end
          end
          default: begin
            state <= IDLE;
            pc    <= '0;
            iter  <= '0;
          end
        endcase
      end
    end
  end

  // Decoder-facing outputs; the instruction is a combinational read at the current pc
  always_comb begin
    busy_o       = busy;
    inst_valid_o = issue;
    pc_o         = pc;
    done_o       = done_q;
    inst_code_o  = busy ? mem[pc] : '0;
  end

endmodule
